// File: rtl/win_addr_gen.sv
// win_addr_gen: image-window address generator (img2col order).
// On a start pulse it latches a layer command, checks it, and streams one
// image-memory word address per window element. The loop order is output
// row, output column, kernel row, kernel column, and channel innermost.
// When the stream ends it pulses done.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   start          one-cycle launch pulse, sampled only in IDLE
//   op_type        000 idle, 001 conv, 100 max pool, 101 avg pool
//   stride, kernel window step and window side K
//   i_side, o_side input and output feature-map sides
//   i_channel      number of input channels
//   addr           registered read word address
//   addr_valid     addr is valid (held while addr_ready is low)
//   addr_ready     consumer accepts addr
//   win_last       addr is the last element of its window
//   busy           high in CHECK and RUN
//   done           one-cycle completion pulse
//   err            one-cycle pulse with done when the config is rejected
module win_addr_gen #(
    parameter int          ADDR_W   = 32,
    parameter logic [31:0] IMG_BASE = 32'h000A_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        op_type,
    input  logic [3:0]        stride,
    input  logic [7:0]        kernel,
    input  logic [7:0]        i_side,
    input  logic [7:0]        o_side,
    input  logic [15:0]       i_channel,
    output logic [ADDR_W-1:0] addr,
    output logic              addr_valid,
    input  logic              addr_ready,
    output logic              win_last,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q;

    // Latched command
    logic [2:0]  op_q;
    logic [3:0]  stride_q;
    logic [7:0]  k_q;
    logic [7:0]  iside_q;
    logic [7:0]  oside_q;
    logic [15:0] ich_q;

    // Odometer counters
    logic [7:0]  oy_q, ox_q, ky_q, kx_q;
    logic [15:0] c_q;
    logic [7:0]  oy_d, ox_d, ky_d, kx_d;
    logic [15:0] c_d;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              addr_valid_q, win_last_q, win_last_d;
    logic              busy_q, done_q, err_q;

    logic              last_c, last_kx, last_ky, last_ox, last_oy, stream_end;
    logic              op_ok, cfg_bad;
    logic [16:0]       span;
    logic [ADDR_W-1:0] iy, ix;

    // Config evaluation on the latched command
    always_comb begin
        op_ok   = (op_q == 3'b001) || (op_q == 3'b100) || (op_q == 3'b101);
        // Input extent covered by the last window; 17 bits cannot overflow.
        span    = (17'(oside_q) - 17'd1) * 17'(stride_q) + 17'(k_q);
        cfg_bad = (stride_q == 4'd0) || (k_q == 8'd0) || (oside_q == 8'd0) ||
                  (ich_q == 16'd0) || (span > 17'(iside_q));
    end

    // Next counter values after a handshake, and the address they select
    always_comb begin
        last_c     = (c_q  == ich_q - 16'd1);
        last_kx    = (kx_q == k_q - 8'd1);
        last_ky    = (ky_q == k_q - 8'd1);
        last_ox    = (ox_q == oside_q - 8'd1);
        last_oy    = (oy_q == oside_q - 8'd1);
        stream_end = last_c && last_kx && last_ky && last_ox && last_oy;

        c_d  = last_c ? 16'd0 : c_q + 16'd1;
        kx_d = kx_q;
        ky_d = ky_q;
        ox_d = ox_q;
        oy_d = oy_q;
        if (last_c) begin
            kx_d = last_kx ? 8'd0 : kx_q + 8'd1;
            if (last_kx) begin
                ky_d = last_ky ? 8'd0 : ky_q + 8'd1;
                if (last_ky) begin
                    ox_d = last_ox ? 8'd0 : ox_q + 8'd1;
                    if (last_ox) begin
                        oy_d = oy_q + 8'd1;
                    end
                end
            end
        end

        win_last_d = (ky_d == k_q - 8'd1) && (kx_d == k_q - 8'd1) &&
                     (c_d == ich_q - 16'd1);

        iy     = ADDR_W'(oy_d) * ADDR_W'(stride_q) + ADDR_W'(ky_d);
        ix     = ADDR_W'(ox_d) * ADDR_W'(stride_q) + ADDR_W'(kx_d);
        addr_d = ADDR_W'(IMG_BASE) +
                 (iy * ADDR_W'(iside_q) + ix) * ADDR_W'(ich_q) + ADDR_W'(c_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            stride_q     <= '0;
            k_q          <= '0;
            iside_q      <= '0;
            oside_q      <= '0;
            ich_q        <= '0;
            oy_q         <= '0;
            ox_q         <= '0;
            ky_q         <= '0;
            kx_q         <= '0;
            c_q          <= '0;
            addr_q       <= '0;
            addr_valid_q <= 1'b0;
            win_last_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q     <= op_type;
                        stride_q <= stride;
                        k_q      <= kernel;
                        iside_q  <= i_side;
                        oside_q  <= o_side;
                        ich_q    <= i_channel;
                        busy_q   <= 1'b1;
                        state_q  <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (!op_ok || cfg_bad) begin
                        // Idle opcode ends quietly; a bad geometry is flagged.
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= op_ok;
                        state_q <= S_DONE;
                    end else begin
                        oy_q         <= '0;
                        ox_q         <= '0;
                        ky_q         <= '0;
                        kx_q         <= '0;
                        c_q          <= '0;
                        addr_q       <= ADDR_W'(IMG_BASE);
                        addr_valid_q <= 1'b1;
                        win_last_q   <= (k_q == 8'd1) && (ich_q == 16'd1);
                        state_q      <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (addr_valid_q && addr_ready) begin
                        if (stream_end) begin
                            addr_q       <= '0;
                            addr_valid_q <= 1'b0;
                            win_last_q   <= 1'b0;
                            busy_q       <= 1'b0;
                            done_q       <= 1'b1;
                            state_q      <= S_DONE;
                        end else begin
                            oy_q       <= oy_d;
                            ox_q       <= ox_d;
                            ky_q       <= ky_d;
                            kx_q       <= kx_d;
                            c_q        <= c_d;
                            addr_q     <= addr_d;
                            win_last_q <= win_last_d;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign addr       = addr_q;
    assign addr_valid = addr_valid_q;
    assign win_last   = win_last_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule
